timebase_gen: RTL and testbench

- Parametrised multi-channel timebase generator for the stopwatch and later designs.
- From the single 50 MHz system clock it produces NUM_CH independent single-cycle `tick` strobes, one per channel. Each channel has a divisor that is set at reset and rewritable at run time. Optional 50% square outputs are also available.
- Downstream logic (centisecond counter, display multiplexer) runs on `clk_50MHz` and uses `tick` as a clock enable. No derived clocks are generated.

---
 rtl/timebase_gen.sv | 55 +++++
 tb/tb_timebase_gen.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/timebase_gen.sv
// timebase_gen: multi-channel divisor-based tick strobes for use as clock enables.
// Define TIMEBASE_SQ_EN to build the 50% square outputs; otherwise sq is tied to 0.
module timebase_gen #(
   parameter int NUM_CH = 2,
   parameter int CNT_W = 20,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {20'd50_000, 20'd500_000}
) (
   input  logic              clk_50MHz,
   input  logic              rst_n,
   input  logic              en,
   input  logic              sync_clr,
   input  logic              div_wr,
   input  logic [2:0]        div_sel,
   input  logic [CNT_W-1:0]  div_data,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq
);
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [CNT_W-1:0] div_d, div_q, cnt_d, cnt_q;
      logic tick_d, tick_q, wr, run, wrap;
      // an out-of-range div_sel never matches any channel index, so it is ignored
      assign wr = div_wr && (div_sel == 3'(k));
      always_comb begin
         div_d  = wr ? div_data : div_q;
         run    = !sync_clr && !wr && en && (div_q != '0);
         wrap   = run && (cnt_q == div_q - CNT_W'(1));
         tick_d = wrap;
         cnt_d  = (sync_clr || wr || wrap || (en && div_q == '0)) ? '0 :
                  run ? cnt_q + CNT_W'(1) : cnt_q;
      end
      always_ff @(posedge clk_50MHz or negedge rst_n) begin
         if (!rst_n) begin
            div_q  <= DIV_INIT[k*CNT_W +: CNT_W];
            cnt_q  <= '0;
            tick_q <= 1'b0;
         end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
         end
      end
      assign tick[k] = tick_q;
`ifdef TIMEBASE_SQ_EN
      logic sq_d, sq_q;
      always_comb sq_d = sync_clr ? 1'b0 : wrap ? ~sq_q : sq_q;
      always_ff @(posedge clk_50MHz or negedge rst_n) begin
         if (!rst_n) sq_q <= 1'b0;
         else sq_q <= sq_d;
      end
      assign sq[k] = sq_q;
`else
      assign sq[k] = 1'b0;
`endif
   end
endmodule

// File: tb/tb_timebase_gen.sv
// tb_timebase_gen: directed test-plan scenarios plus random traffic against an elapsed-cycle model.
module tb_timebase_gen;
   localparam int NCH = 3;
   localparam int W = 8;
   localparam logic [NCH*W-1:0] INIT = {8'd0, 8'd1, 8'd4};

   logic clk_50MHz = 1'b0, rst_n = 1'b0, en = 1'b0, sync_clr = 1'b0, div_wr = 1'b0;
   logic [2:0] div_sel = '0;
   logic [W-1:0] div_data = '0;
   logic [NCH-1:0] tick, sq;

   timebase_gen #(.NUM_CH(NCH), .CNT_W(W), .DIV_INIT(INIT)) dut (
      .clk_50MHz(clk_50MHz), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
      .div_wr(div_wr), .div_sel(div_sel), .div_data(div_data), .tick(tick), .sq(sq)
   );

   always #10 clk_50MHz = ~clk_50MHz;

   int n_cmp = 0, n_err = 0;
   // model: divisor, enabled cycles since last restart, square toggles since last clear
   int mdiv[NCH], el[NCH], tog[NCH], texp[NCH], seen[NCH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NCH; k++) begin
         mdiv[k] = int'(INIT[k*W +: W]);
         el[k] = 0; tog[k] = 0; texp[k] = 0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < NCH; k++) begin
         bit wr;
         wr = div_wr && (int'(div_sel) == k);
         texp[k] = 0;
         if (wr) mdiv[k] = int'(div_data);
         if (sync_clr) begin el[k] = 0; tog[k] = 0; end
         else if (wr) el[k] = 0;
         else if (!en) ;
         else if (mdiv[k] == 0) el[k] = 0;
         else begin
            el[k]++;
            if (el[k] % mdiv[k] == 0) begin texp[k] = 1; tog[k]++; end
         end
      end
   endtask

   task automatic check_outs();
      for (int k = 0; k < NCH; k++) begin
         chk($sformatf("tick%0d", k), 32'(tick[k]), 32'(texp[k]));
`ifdef TIMEBASE_SQ_EN
         chk($sformatf("sq%0d", k), 32'(sq[k]), 32'(tog[k] & 1));
`else
         chk($sformatf("sq%0d", k), 32'(sq[k]), 32'd0);
`endif
      end
   endtask

   task automatic clr_seen();
      for (int k = 0; k < NCH; k++) seen[k] = 0;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk_50MHz);
         model_edge();
         #1;
         check_outs();
         for (int k = 0; k < NCH; k++) if (tick[k]) seen[k]++;
      end
   endtask

   initial begin
      model_reset();
      #15;
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_sq", 32'(sq), 32'd0);
      en = 1'b1;
      #10 rst_n = 1'b1;
      clr_seen();
      cyc(20);
      chk("ch0_ticks20", seen[0], 5);
      chk("ch1_ticks20", seen[1], 20);
      chk("ch2_ticks20", seen[2], 0);
      for (int g = 0; g < 8 && el[0] % 4 != 2; g++) cyc(1);
      chk("ch0_phase", el[0] % 4, 2);
      en = 1'b0;
      clr_seen();
      cyc(5);
      chk("pause_ch0", seen[0], 0);
      chk("pause_ch1", seen[1], 0);
      en = 1'b1;
      clr_seen();
      cyc(6);
      chk("resume_ch0", seen[0], 2);
      div_wr = 1'b1; div_sel = 3'd2; div_data = 8'd3;
      cyc(1);
      div_wr = 1'b0;
      clr_seen();
      cyc(9);
      chk("wr_ch2_ticks", seen[2], 3);
      div_wr = 1'b1; div_sel = 3'd5; div_data = 8'd9;
      cyc(1);
      div_wr = 1'b0;
      cyc(8);
      sync_clr = 1'b1; div_wr = 1'b1; div_sel = 3'd0; div_data = 8'd2;
      cyc(1);
      sync_clr = 1'b0; div_wr = 1'b0;
      clr_seen();
      cyc(8);
      chk("clrwr_ch0_ticks", seen[0], 4);
      div_wr = 1'b1; div_sel = 3'd0; div_data = 8'd7;
      cyc(1);
      div_wr = 1'b0;
      cyc(3);
      rst_n = 1'b0;
      #1;
      chk("async_rst_tick", 32'(tick), 32'd0);
      chk("async_rst_sq", 32'(sq), 32'd0);
      model_reset();
      #5 rst_n = 1'b1;
      clr_seen();
      cyc(12);
      chk("post_rst_ch0", seen[0], 3);
      repeat (400) begin
         en = $urandom_range(0, 9) != 0;
         sync_clr = $urandom_range(0, 29) == 0;
         div_wr = $urandom_range(0, 14) == 0;
         div_sel = 3'($urandom_range(0, 7));
         div_data = 8'($urandom_range(0, 6));
         cyc(1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
